program_loader: RTL

Boot-time writer for the instruction memory: receives a program as a byte stream over a valid/ready interface, assembles little-endian 32-bit words and writes them sequentially into instruction memory, starting at word 0. While loading, it holds the core in reset. On completion it releases the core so that fetch begins from address 0. It sits between the host byte source (UART receiver or testbench) and the instruction memory write port, beside the core top level.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_if.sv | 42 ++++
 rtl/program_loader_word_assembler.sv | 44 ++++
 rtl/program_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader.
// Optional checksum support is selected with LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef logic [31:0] word;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int unsigned LOADER_LEN_BYTES = 2;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and core control of the loader.
// master: byte source / observer side; slave: the loader itself.
interface program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    import program_loader_pkg::*;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_wr_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    word                   imem_wr_data;
    logic                  core_reset;
    logic                  done;
    logic                  error;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data,
        input  core_reset,
        input  done,
        input  error
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data,
        output core_reset,
        output done,
        output error
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs four accepted bytes into one little-endian word; word_valid_o pulses with the 4th byte.
module program_loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_i,
    input  logic       byte_strobe_i,
    output word        word_o,
    output logic       word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] lo_q, lo_d;

    always_comb begin
        cnt_d = cnt_q;
        lo_d  = lo_q;
        if (byte_strobe_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    lo_d[7:0]   = byte_i;
                2'd1:    lo_d[15:8]  = byte_i;
                2'd2:    lo_d[23:16] = byte_i;
                default: lo_d        = lo_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 2'd0;
            lo_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            lo_q  <= lo_d;
        end
    end

    // The 4th byte is forwarded directly so the write can be registered on the same edge.
    assign word_o       = {byte_i, lo_q};
    assign word_valid_o = byte_strobe_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the core in reset.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic            clock,
    input  logic            reset,
    program_loader_if.slave bus
);

    localparam int unsigned LenBits = 8 * LOADER_LEN_BYTES;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t StAfterData = S_CSUM;
`else
    localparam loader_state_t StAfterData = S_DONE;
`endif

    loader_state_t         state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [LenBits-1:0]    len_q, len_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    word                   wr_data_q, wr_data_d;
    logic                  core_reset_q, core_reset_d;

    logic               xfer;
    logic               byte_strobe;
    logic               word_valid;
    word                asm_word;
    logic [LenBits-1:0] len_rx;
    logic               last_word;

    assign xfer        = bus.rx_valid && bus.rx_ready;
    assign byte_strobe = xfer && (state_q == S_DATA);
    assign len_rx      = {bus.rx_data, len_lo_q};
    assign last_word   = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign csum_d = byte_strobe ? (csum_q ^ bus.rx_data) : csum_q;

    always_ff @(posedge clock) begin
        if (reset) csum_q <= 8'd0;
        else       csum_q <= csum_d;
    end
`endif

    program_loader_word_assembler u_word_assembler (
        .clock         (clock),
        .reset         (reset),
        .byte_i        (bus.rx_data),
        .byte_strobe_i (byte_strobe),
        .word_o        (asm_word),
        .word_valid_o  (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_LEN_LO;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_LO: if (xfer) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_rx == '0) begin
                        state_d = StAfterData;
                    end else if (32'(len_rx) > (32'd1 << ADDR_WIDTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: if (word_valid && last_word) state_d = StAfterData;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_LEN_LO;
        endcase
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: bus.rx_ready = 1'b1;
            S_DONE:                             bus.done     = 1'b1;
            S_ERROR:                            bus.error    = 1'b1;
            default:                            bus.rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        len_lo_d   = (state_q == S_LEN_LO && xfer) ? bus.rx_data : len_lo_q;
        len_d      = (state_q == S_LEN_HI && xfer) ? len_rx : len_q;
        word_cnt_d = word_valid ? (word_cnt_q + ADDR_WIDTH'(1)) : word_cnt_q;
        wr_en_d    = word_valid;
        wr_addr_d  = word_valid ? word_cnt_q : wr_addr_q;
        wr_data_d  = word_valid ? asm_word : wr_data_q;
        // Lags S_DONE by a cycle so the core leaves reset after the final write has landed.
        core_reset_d = (state_q != S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_lo_q     <= 8'd0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_reset_q <= 1'b1;
        end else begin
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign bus.core_reset   = core_reset_q;

endmodule
